// File: rtl/endscene_pkg.sv
// Shared types and constants for the end-scene text overlay.
package endscene_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SLIDE_IN = 2'd1,
    ST_HOLD     = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  localparam int unsigned BMP_W    = 40;
  localparam int unsigned BMP_H    = 32;
  localparam int unsigned ROW_AW   = 5;
  localparam int unsigned COL_W    = 6;
  localparam int unsigned COORD_W  = 10;
  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

endpackage

// File: rtl/endscene_pix_pipe.sv
// Two-stage beam-coordinate to bitmap-bit pipeline: stage 1 issues the ROM row
// address, stage 2 picks the column bit from the returned row.
module endscene_pix_pipe
  import endscene_pkg::*;
#(
  parameter int unsigned X_POS      = 240,
  parameter int unsigned SCALE_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [COORD_W-1:0]  draw_x_i,
  input  logic [COORD_W-1:0]  draw_y_i,
  input  logic [COORD_W-1:0]  text_y_i,
  input  logic [BMP_W-1:0]    rom_data_i,
  input  logic                gate_i,
  output logic [ROW_AW-1:0]   rom_addr_o,
  output logic                text_on_o
);

  localparam int unsigned DW = COORD_W + 1;
  localparam logic [DW-1:0] BOX_W = DW'(BMP_W << SCALE_LOG2);
  localparam logic [DW-1:0] BOX_H = DW'(BMP_H << SCALE_LOG2);

  logic [DW-1:0]     dx_c, dy_c;
  logic              in_box_c;
  logic [ROW_AW-1:0] row_c;
  logic [COL_W-1:0]  col_c, bit_idx_c;

  logic [ROW_AW-1:0] rom_addr_q;
  logic [COL_W-1:0]  col_q;
  logic              in_box_q;
  logic              text_on_q;

  // Differences are 11 bits wide so a beam left of / above the box shows up as a set sign bit.
  always_comb begin
    dx_c      = DW'(draw_x_i) - DW'(X_POS);
    dy_c      = DW'(draw_y_i) - DW'(text_y_i);
    in_box_c  = !dx_c[DW-1] && (dx_c < BOX_W) && !dy_c[DW-1] && (dy_c < BOX_H);
    row_c     = in_box_c ? ROW_AW'(dy_c >> SCALE_LOG2) : '0;
    col_c     = in_box_c ? COL_W'(dx_c >> SCALE_LOG2) : '0;
    bit_idx_c = COL_W'(BMP_W - 1) - col_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_q <= '0;
      col_q      <= '0;
      in_box_q   <= 1'b0;
      text_on_q  <= 1'b0;
    end else begin
      rom_addr_q <= row_c;
      col_q      <= col_c;
      in_box_q   <= in_box_c;
      text_on_q  <= in_box_q & rom_data_i[bit_idx_c] & gate_i;
    end
  end

  assign rom_addr_o = rom_addr_q;
  assign text_on_o  = text_on_q;

endmodule

// File: rtl/endscene_overlay.sv
// End-scene overlay: slides the bitmap text to rest, holds it, then reports done.
// Define ENDSCENE_BLINK_EN to blink the text while holding.
module endscene_overlay
  import endscene_pkg::*;
#(
  parameter int unsigned SCALE_LOG2  = 2,
  parameter int unsigned X_POS       = 240,
  parameter int unsigned Y_START     = 0,
  parameter int unsigned Y_FINAL     = 176,
  parameter int unsigned SLIDE_STEP  = 4,
  parameter int unsigned HOLD_FRAMES = 180
`ifdef ENDSCENE_BLINK_EN
  ,
  parameter int unsigned BLINK_FRAMES = 30
`endif
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                frame_clk,
  input  logic                game_over,
  input  logic                restart,
  input  logic [COORD_W-1:0]  DrawX,
  input  logic [COORD_W-1:0]  DrawY,
  output logic [ROW_AW-1:0]   rom_addr,
  input  logic [BMP_W-1:0]    rom_data,
  output logic                text_on,
  output logic                overlay_active,
  output logic                scene_done
);

  localparam int unsigned HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  state_e              state_q, state_d;
  logic [COORD_W-1:0]  text_y_q, text_y_d, next_y_c;
  logic [COORD_W:0]    slide_sum_c;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                frame_q, tick_c;
  logic                overlay_active_q, scene_done_q;
  logic                blink_vis;

  assign tick_c      = frame_clk & ~frame_q;
  assign slide_sum_c = (COORD_W+1)'(text_y_q) + (COORD_W+1)'(SLIDE_STEP);
  assign next_y_c    = (slide_sum_c >= (COORD_W+1)'(Y_FINAL)) ? COORD_W'(Y_FINAL)
                                                              : slide_sum_c[COORD_W-1:0];

  always_comb begin
    state_d    = state_q;
    text_y_d   = text_y_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (game_over) begin
          state_d  = ST_SLIDE_IN;
          text_y_d = COORD_W'(Y_START);
        end
      end
      ST_SLIDE_IN: begin
        if (tick_c) begin
          text_y_d = next_y_c;
          if (next_y_c == COORD_W'(Y_FINAL)) begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
          end
        end
      end
      ST_HOLD: begin
        if (tick_c) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          if (hold_cnt_q == HOLD_W'(HOLD_FRAMES - 1)) state_d = ST_DONE;
        end
      end
      default: ;
    endcase
    // restart wins over any same-cycle start pulse or tick
    if (restart) state_d = ST_IDLE;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q          <= ST_IDLE;
      text_y_q         <= COORD_W'(Y_START);
      hold_cnt_q       <= '0;
      frame_q          <= 1'b0;
      overlay_active_q <= 1'b0;
      scene_done_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      text_y_q         <= text_y_d;
      hold_cnt_q       <= hold_cnt_d;
      frame_q          <= frame_clk;
      overlay_active_q <= (state_d != ST_IDLE);
      scene_done_q     <= (state_d == ST_DONE);
    end
  end

`ifdef ENDSCENE_BLINK_EN
  localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_vis_q, blink_vis_d;

  // Blink phase restarts visible on every entry to HOLD and is forced visible elsewhere.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_vis_d = blink_vis_q;
    if (state_d != ST_HOLD || state_q != ST_HOLD) begin
      blink_cnt_d = '0;
      blink_vis_d = 1'b1;
    end else if (tick_c) begin
      if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        blink_vis_d = ~blink_vis_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      blink_cnt_q <= '0;
      blink_vis_q <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_vis_q <= blink_vis_d;
    end
  end

  assign blink_vis = blink_vis_q;
`else
  assign blink_vis = 1'b1;
`endif

  endscene_pix_pipe #(
    .X_POS      (X_POS),
    .SCALE_LOG2 (SCALE_LOG2)
  ) u_pix_pipe (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .draw_x_i   (DrawX),
    .draw_y_i   (DrawY),
    .text_y_i   (text_y_q),
    .rom_data_i (rom_data),
    .gate_i     (overlay_active_q & blink_vis),
    .rom_addr_o (rom_addr),
    .text_on_o  (text_on)
  );

  assign overlay_active = overlay_active_q;
  assign scene_done     = scene_done_q;

endmodule

// File: tb/tb_endscene_overlay.sv
// Scoreboarded random-pixel bench for endscene_overlay against a frame-level model.
module tb_endscene_overlay;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_clk = 1'b0;
  logic        game_over = 1'b0;
  logic        restart = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic [4:0]  rom_addr;
  logic [39:0] rom_data;
  logic        text_on;
  logic        overlay_active;
  logic        scene_done;

  logic [39:0] rom_mem [32];
  assign rom_data = rom_mem[rom_addr];

  endscene_overlay dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .frame_clk      (frame_clk),
    .game_over      (game_over),
    .restart        (restart),
    .DrawX          (DrawX),
    .DrawY          (DrawY),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .text_on        (text_on),
    .overlay_active (overlay_active),
    .scene_done     (scene_done)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct { int due; logic [4:0] v; } exp_t;
  exp_t qa[$];
  exp_t qt[$];

  // Frame-level reference: 0 idle, 1 slide, 2 hold, 3 done
  int m_state = 0;
  int m_ty = 0;
  int m_hold = 0;

  function automatic bit m_vis();
`ifdef ENDSCENE_BLINK_EN
    if (m_state == 2) return ((m_hold / 30) % 2) == 0;
`endif
    return 1'b1;
  endfunction

  function automatic void model_pix(input int x, input int y, output logic [4:0] ea, output logic et);
    int rx, ry;
    bit in_box;
    logic [39:0] row;
    rx = x - 240;
    ry = y - m_ty;
    in_box = (rx >= 0) && (rx < 160) && (ry >= 0) && (ry < 128);
    ea = in_box ? 5'(ry / 4) : 5'd0;
    row = rom_mem[ry / 4 & 31];
    et = in_box && row[39 - rx / 4] && (m_state != 0) && m_vis();
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drain();
    repeat (3) step();
  endtask

  task automatic probe(input int x, input int y);
    logic [4:0] ea;
    logic et;
    exp_t e;
    DrawX = 10'(x);
    DrawY = 10'(y);
    model_pix(x, y, ea, et);
    e.due = cyc + 1; e.v = ea;        qa.push_back(e);
    e.due = cyc + 2; e.v = 5'(et);    qt.push_back(e);
    step();
  endtask

  task automatic burst(input int n);
    int y;
    for (int i = 0; i < n; i++) begin
      y = m_ty + int'($urandom_range(0, 160)) - 16;
      if (y < 0) y = 0;
      probe(int'($urandom_range(220, 420)), y);
    end
    drain();
  endtask

  task automatic do_tick();
    frame_clk = 1'b1;
    step();
    frame_clk = 1'b0;
    step();
    case (m_state)
      1: begin
        m_ty = (m_ty + 4 > 176) ? 176 : m_ty + 4;
        if (m_ty == 176) begin m_state = 2; m_hold = 0; end
      end
      2: begin
        m_hold++;
        if (m_hold == 180) m_state = 3;
      end
      default: ;
    endcase
  endtask

  task automatic pulse_go();
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    if (m_state == 0) begin m_state = 1; m_ty = 0; end
  endtask

  // Monitor: pops expectations whose pipeline slot is the current cycle.
  always @(negedge Clk) begin : mon
    exp_t e;
    if (Reset_n) begin
      while (qa.size() > 0 && qa[0].due <= cyc) begin
        e = qa.pop_front();
        checks++;
        if (e.due != cyc || rom_addr !== e.v) begin
          errors++;
          $display("FAIL rom_addr: got %0d expected %0d (due %0d, cyc %0d)", rom_addr, e.v, e.due, cyc);
        end
      end
      while (qt.size() > 0 && qt[0].due <= cyc) begin
        e = qt.pop_front();
        checks++;
        if (e.due != cyc || text_on !== e.v[0]) begin
          errors++;
          $display("FAIL text_on: got %0b expected %0b (due %0d, cyc %0d)", text_on, e.v[0], e.due, cyc);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) rom_mem[i] = {8'($urandom), $urandom};
    rom_mem[2][39] = 1'b0;
    rom_mem[2][34] = 1'b1;

    repeat (3) step();
    chk("reset overlay_active", 32'(overlay_active), 0);
    chk("reset scene_done", 32'(scene_done), 0);
    chk("reset text_on", 32'(text_on), 0);
    chk("reset rom_addr", 32'(rom_addr), 0);
    Reset_n = 1'b1;
    step();

    // Idle: box sits at Y_START but text is never drawn
    burst(12);
    chk("idle overlay_active", 32'(overlay_active), 0);

    // Slide part way (text_y = 100), then reset asynchronously
    pulse_go();
    chk("go overlay_active", 32'(overlay_active), 1);
    for (int t = 0; t < 25; t++) begin
      do_tick();
      if (t % 5 == 0) burst(4);
    end
    probe(260, 100 + 8);
    probe(260, 100 + 9);
    drain();
    #2;
    Reset_n = 1'b0;
    #1;
    chk("async rst overlay_active", 32'(overlay_active), 0);
    chk("async rst scene_done", 32'(scene_done), 0);
    chk("async rst text_on", 32'(text_on), 0);
    chk("async rst rom_addr", 32'(rom_addr), 0);
    m_state = 0; m_ty = 0; m_hold = 0;
    step();
    Reset_n = 1'b1;
    step();
    burst(6);

    // Full slide: 44 ticks to rest
    pulse_go();
    for (int t = 1; t <= 44; t++) begin
      do_tick();
      chk("slide overlay_active", 32'(overlay_active), 1);
      chk("slide scene_done", 32'(scene_done), 0);
      burst(3);
    end
    chk("model reached hold", 32'(m_state), 2);

    // Box edges at rest
    probe(240, 184);
    probe(260, 184);
    probe(239, 184);
    probe(400, 184);
    probe(399, 303);
    probe(250, 304);
    probe(250, 175);
    probe(250, 176);
    drain();

    // Hold phase
    for (int t = 1; t <= 180; t++) begin
      do_tick();
      chk("hold scene_done", 32'(scene_done), (m_state == 3) ? 1 : 0);
      probe(260, 184);
      if (t % 20 == 0) begin
        drain();
        burst(4);
      end else begin
        drain();
      end
    end

    // Done: game_over ignored, restart beats same-cycle game_over
    burst(6);
    pulse_go();
    chk("done ignores go", 32'(scene_done), 1);
    chk("done overlay_active", 32'(overlay_active), 1);
    probe(260, 184);
    drain();
    restart = 1'b1;
    game_over = 1'b1;
    step();
    restart = 1'b0;
    game_over = 1'b0;
    m_state = 0;
    chk("restart overlay_active", 32'(overlay_active), 0);
    chk("restart scene_done", 32'(scene_done), 0);
    probe(260, 184);
    drain();
    repeat (2) do_tick();
    chk("idle stays idle", 32'(overlay_active), 0);

    // Fresh start after restart
    pulse_go();
    do_tick();
    burst(8);
    chk("restart relaunch", 32'(overlay_active), 1);

    if (qa.size() != 0 || qt.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d/%0d entries left", qa.size(), qt.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
